// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared constants, phase type and hex decoder for the seven-segment scanner
// Contents: default parameter values, SEG_BLANK, phase_e, hex_to_seg (segments gfedcba in [6:0], dp in [7]).
package seven_seg_pkg;
  localparam int DEF_DIGITS = 4;
  localparam int DEF_SEG_WIDTH = 8;
  localparam int DEF_DIV = 10_000;
  localparam int DEF_BLANK = 16;
  localparam int DEF_BRIGHT_BITS = 4;
  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [111:0] HEX_LUT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
  typedef enum logic {PH_BLANK, PH_ON} phase_e;
  function automatic logic [7:0] hex_to_seg(input logic [3:0] h, input logic dp);
    return {dp, HEX_LUT[7*h +: 7]};
  endfunction
endpackage

// File: rtl/seven_seg_scan_timer.sv
// seven_seg_scan_timer: slot/digit/pwm counters that pace the display scan
// Ports: clk, rst (async, active-high), enable; idx = digit being scanned, pwm = on-phase
// counter, phase = blank/on, boundary = last cycle of the frame, frame_first = first cycle of digit 0's slot.
module seven_seg_scan_timer import seven_seg_pkg::*; #(
  parameter int DIGITS = DEF_DIGITS,
  parameter int DIV = DEF_DIV,
  parameter int BLANK = DEF_BLANK,
  parameter int BRIGHT_BITS = DEF_BRIGHT_BITS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  output logic [$clog2(DIGITS)-1:0]   idx,
  output logic [BRIGHT_BITS-1:0]      pwm,
  output phase_e                      phase,
  output logic                        boundary,
  output logic                        frame_first
);
  localparam int SW = $clog2(DIV);
  localparam int IW = $clog2(DIGITS);
  logic [SW-1:0] slot_cnt_q, slot_cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [BRIGHT_BITS-1:0] pwm_q, pwm_d;
  logic slot_end, last_digit;
  always_comb begin
    slot_end = slot_cnt_q == SW'(DIV - 1);
    last_digit = idx_q == IW'(DIGITS - 1);
    phase = slot_cnt_q < SW'(BLANK) ? PH_BLANK : PH_ON;
    boundary = enable && slot_end && last_digit;
    frame_first = enable && slot_cnt_q == '0 && idx_q == '0;
    slot_cnt_d = !enable || slot_end ? '0 : slot_cnt_q + 1'b1;
    idx_d = !enable || (slot_end && last_digit) ? '0 : slot_end ? idx_q + 1'b1 : idx_q;
    pwm_d = !enable || slot_end ? '0 : phase == PH_ON ? pwm_q + 1'b1 : pwm_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt_q <= '0;
      idx_q <= '0;
      pwm_q <= '0;
    end else begin
      slot_cnt_q <= slot_cnt_d;
      idx_q <= idx_d;
      pwm_q <= pwm_d;
    end
  end
  assign idx = idx_q;
  assign pwm = pwm_q;
endmodule

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: N-digit multiplexed seven-segment driver with blanking, PWM and double buffering
// Ports: clk, rst (async, active-high), enable, digits_in/load (staged pattern write),
// brightness; load_pending, frame_start, segments, digit_sel (registered, pin polarity).
module seven_seg_scanner import seven_seg_pkg::*; #(
  parameter int DIGITS = DEF_DIGITS,
  parameter int SEG_WIDTH = DEF_SEG_WIDTH,
  parameter int DIV = DEF_DIV,
  parameter int BLANK = DEF_BLANK,
  parameter int BRIGHT_BITS = DEF_BRIGHT_BITS,
  parameter int SEL_ACTIVE_LOW = 0,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [DIGITS*SEG_WIDTH-1:0]   digits_in,
  input  logic                          load,
  input  logic [BRIGHT_BITS-1:0]        brightness,
  output logic                          load_pending,
  output logic                          frame_start,
  output logic [SEG_WIDTH-1:0]          segments,
  output logic [DIGITS-1:0]             digit_sel
);
  localparam int IW = $clog2(DIGITS);
  localparam int W = DIGITS * SEG_WIDTH;
  localparam logic [DIGITS-1:0] SEL_OFF = SEL_ACTIVE_LOW != 0 ? '1 : '0;
  localparam logic [SEG_WIDTH-1:0] SEG_OFF = SEG_ACTIVE_LOW != 0 ? '1 : '0;
  logic [IW-1:0] idx;
  logic [BRIGHT_BITS-1:0] pwm;
  phase_e phase;
  logic boundary, frame_first, lit;
  logic [W-1:0] staging_q, staging_d, active_q, active_d;
  logic pending_q, pending_d, en_q, fs_q, fs_d;
  logic [BRIGHT_BITS-1:0] bright_q, bright_d;
  logic [DIGITS-1:0] sel_q, sel_d;
  logic [SEG_WIDTH-1:0] seg_q, seg_d;
  seven_seg_scan_timer #(
    .DIGITS(DIGITS),
    .DIV(DIV),
    .BLANK(BLANK),
    .BRIGHT_BITS(BRIGHT_BITS)
  ) u_timer (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .idx(idx),
    .pwm(pwm),
    .phase(phase),
    .boundary(boundary),
    .frame_first(frame_first)
  );
  // A load landing on the boundary bypasses staging so it is never left pending.
  // Inversion is folded in before the flops so pins switch cleanly from a register.
  always_comb begin
    lit = enable && phase == PH_ON && (pwm < bright_q || &bright_q);
    staging_d = load ? digits_in : staging_q;
    active_d = boundary ? (load ? digits_in : staging_q) : active_q;
    pending_d = boundary ? 1'b0 : load ? 1'b1 : pending_q;
    bright_d = boundary || (enable && !en_q) ? brightness : bright_q;
    sel_d = (lit ? DIGITS'(1) << idx : '0) ^ SEL_OFF;
    seg_d = (lit ? active_q[idx*SEG_WIDTH +: SEG_WIDTH] : '0) ^ SEG_OFF;
    fs_d = frame_first;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      staging_q <= '0;
      active_q <= '0;
      pending_q <= 1'b0;
      bright_q <= '0;
      en_q <= 1'b0;
      fs_q <= 1'b0;
      sel_q <= SEL_OFF;
      seg_q <= SEG_OFF;
    end else begin
      staging_q <= staging_d;
      active_q <= active_d;
      pending_q <= pending_d;
      bright_q <= bright_d;
      en_q <= enable;
      fs_q <= fs_d;
      sel_q <= sel_d;
      seg_q <= seg_d;
    end
  end
  assign load_pending = pending_q;
  assign frame_start = fs_q;
  assign segments = seg_q;
  assign digit_sel = sel_q;
endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: scanner checked against a time-indexed reference model, both pin polarities
module tb_seven_seg_scanner;
  localparam int DIGITS = 4;
  localparam int DIV = 8;
  localparam int BLANK = 2;
  localparam int BB = 2;
  localparam int FRAME = DIGITS * DIV;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic load = 1'b0;
  logic [31:0] digits_in = '0;
  logic [BB-1:0] brightness = '0;
  logic lp, fs, lp_i, fs_i;
  logic [7:0] seg, seg_i, e_seg, e_seg_i;
  logic [3:0] sel, sel_i, e_sel, e_sel_i;
  logic e_fs;
  int errors = 0;
  int checks = 0;
  int t = 0;
  logic [31:0] m_act = '0;
  logic [31:0] m_stg = '0;
  logic m_pend = 1'b0;
  logic m_en = 1'b0;
  logic [BB-1:0] m_br = '0;
  always #5 clk = ~clk;
  seven_seg_scanner #(
    .DIGITS(DIGITS), .SEG_WIDTH(8), .DIV(DIV), .BLANK(BLANK), .BRIGHT_BITS(BB),
    .SEL_ACTIVE_LOW(0), .SEG_ACTIVE_LOW(0)
  ) u_dut (
    .clk(clk), .rst(rst), .enable(enable), .digits_in(digits_in), .load(load),
    .brightness(brightness), .load_pending(lp), .frame_start(fs), .segments(seg), .digit_sel(sel)
  );
  seven_seg_scanner #(
    .DIGITS(DIGITS), .SEG_WIDTH(8), .DIV(DIV), .BLANK(BLANK), .BRIGHT_BITS(BB),
    .SEL_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)
  ) u_inv (
    .clk(clk), .rst(rst), .enable(enable), .digits_in(digits_in), .load(load),
    .brightness(brightness), .load_pending(lp_i), .frame_start(fs_i), .segments(seg_i), .digit_sel(sel_i)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
    end
  endtask
  task automatic tick();
    int pos, d, j;
    logic bnd;
    e_sel = '0;
    e_seg = '0;
    e_fs = 1'b0;
    bnd = 1'b0;
    if (enable) begin
      pos = t % DIV;
      d = (t / DIV) % DIGITS;
      j = pos - BLANK;
      if (pos >= BLANK && ((j % (1 << BB)) < int'(m_br) || m_br == '1)) begin
        e_sel = 4'(1 << d);
        e_seg = m_act[d*8 +: 8];
      end
      e_fs = (t % FRAME) == 0;
      bnd = (t % FRAME) == FRAME - 1;
    end
    e_sel_i = ~e_sel;
    e_seg_i = ~e_seg;
    if (bnd) begin
      m_act = load ? digits_in : m_stg;
      if (load) m_stg = digits_in;
      m_pend = 1'b0;
    end else if (load) begin
      m_stg = digits_in;
      m_pend = 1'b1;
    end
    if (bnd || (enable && !m_en)) m_br = brightness;
    m_en = enable;
    t = enable ? t + 1 : 0;
    @(posedge clk);
    #1;
    chk("sel", sel, e_sel);
    chk("seg", seg, e_seg);
    chk("frame_start", fs, e_fs);
    chk("load_pending", lp, m_pend);
    chk("sel_inv", sel_i, e_sel_i);
    chk("seg_inv", seg_i, e_seg_i);
    chk("frame_start_inv", fs_i, e_fs);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_sel", sel, 4'h0);
    chk("rst_seg", seg, 8'h00);
    chk("rst_sel_inv", sel_i, 4'hF);
    chk("rst_seg_inv", seg_i, 8'hFF);
    chk("rst_pending", lp, 1'b0);
    chk("rst_frame_start", fs, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    t = 0;
    m_act = '0;
    m_stg = '0;
    m_pend = 1'b0;
    m_en = 1'b0;
    m_br = '0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog t=%0d", t);
    $fatal(1, "watchdog expired");
  end
  initial begin
    do_reset();
    enable = 1'b1;
    brightness = 2'd3;
    repeat (5) tick();
    digits_in = 32'h1122_3344;
    load = 1'b1;
    tick();
    load = 1'b0;
    repeat (2 * FRAME) tick();
    brightness = 2'd2;
    repeat (2 * FRAME) tick();
    brightness = 2'd0;
    repeat (2 * FRAME) tick();
    brightness = 2'd3;
    repeat (FRAME) tick();
    while (t % FRAME != 10) tick();
    digits_in = 32'hAAAA_AAAA;
    load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    digits_in = 32'hBBBB_BBBB;
    load = 1'b1;
    tick();
    load = 1'b0;
    repeat (2 * FRAME) tick();
    while (t % FRAME != FRAME - 1) tick();
    digits_in = 32'h5566_7788;
    load = 1'b1;
    tick();
    load = 1'b0;
    repeat (FRAME + 4) tick();
    while (!((t / DIV) % DIGITS == 2 && t % DIV == 4)) tick();
    do_reset();
    repeat (FRAME) tick();
    while (!((t / DIV) % DIGITS == 3 && t % DIV == 4)) tick();
    enable = 1'b0;
    brightness = 2'd1;
    repeat (5) tick();
    enable = 1'b1;
    repeat (2 * FRAME) tick();
    repeat (800) begin
      enable = $urandom_range(0, 19) != 0;
      load = $urandom_range(0, 15) == 0;
      digits_in = $urandom;
      brightness = BB'($urandom);
      tick();
    end
    load = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
